// File: rtl/gray_pkg.sv
// Shared definitions for the gray-image memory path: image geometry, pixel
// bus widths and the arbiter state encoding.
package gray_pkg;

   localparam int IMG_W = 128;
   localparam int IMG_H = 128;
   localparam int AW    = $clog2(IMG_W * IMG_H);
   localparam int DW    = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      LOCK = 2'd2
   } arb_state_t;

endpackage

// File: rtl/gray_mem_arb_if.sv
// Requester and gray-memory signals of the arbiter.
// The master modport is the arbiter; the slave modport is the engines plus the memory.
interface gray_mem_arb_if #(
   parameter int NREQ = 2,
   parameter int AW   = gray_pkg::AW,
   parameter int DW   = gray_pkg::DW
) ();

   logic               mem_ready;
   logic               mem_req;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_data;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    req_lock;
   logic [NREQ-1:0]    req_grant;
   logic [NREQ-1:0]    rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               busy;

   modport master (
      input  mem_ready, mem_data, req_valid, req_addr, req_lock,
      output mem_req, mem_addr, req_grant, rsp_valid, rsp_data, busy
   );

   modport slave (
      output mem_ready, mem_data, req_valid, req_addr, req_lock,
      input  mem_req, mem_addr, req_grant, rsp_valid, rsp_data, busy
   );

endinterface

// File: rtl/gray_mem_arb_rr_pick.sv
// Combinational round-robin picker: the first valid requester after index
// 'last', wrapping around, returned as a one-hot vector and as an index.
module rr_pick #(
   parameter int N  = 2,
   parameter int LW = 1
) (
   input  logic [N-1:0]  valid,
   input  logic [LW-1:0] last,
   output logic [N-1:0]  onehot,
   output logic [LW-1:0] idx,
   output logic          found
);

   // First scan above 'last', then wrap to the indices at or below it.
   always_comb begin
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!found && valid[i] && (i > int'(last))) begin
            onehot[i] = 1'b1;
            idx       = LW'(i);
            found     = 1'b1;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && valid[i] && (i <= int'(last))) begin
            onehot[i] = 1'b1;
            idx       = LW'(i);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gray_mem_arb.sv
// Round-robin arbiter sharing the single-port gray memory among NREQ pixel
// requesters, with bounded burst locking and a fixed two-cycle return path.
module gray_mem_arb #(
   parameter int NREQ     = 2,
   parameter int AW       = gray_pkg::AW,
   parameter int DW       = gray_pkg::DW,
   parameter int LOCK_MAX = 3
) (
   input logic             clk,
   input logic             reset,
   gray_mem_arb_if.master  bus
);

   import gray_pkg::*;

   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(LOCK_MAX + 1);

   arb_state_t      state, state_nx;
   logic [LW-1:0]   last_winner, owner_d1, win_idx;
   logic [CW-1:0]   lock_cnt, cnt_nx;
   logic [NREQ-1:0] owner_oh, others, d1_oh;
   logic [NREQ-1:0] rr_oh, oth_oh, grant_oh;
   logic [LW-1:0]   rr_idx, oth_idx;
   logic            rr_found, oth_found, owner_valid, owner_lock, new_owner;
   logic [AW-1:0]   win_addr;
   logic            mem_req_q;
   logic [AW-1:0]   mem_addr_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [DW-1:0]   rsp_data_q;

   // In LOCK the owner is always the last winner.
   always_comb begin
      owner_oh = '0;
      d1_oh    = '0;
      for (int i = 0; i < NREQ; i++) begin
         owner_oh[i] = (LW'(i) == last_winner);
         d1_oh[i]    = (LW'(i) == owner_d1);
      end
   end

   assign owner_valid = |(bus.req_valid & owner_oh);
   assign owner_lock  = |(bus.req_lock & owner_oh);
   assign others      = bus.req_valid & ~owner_oh;

   rr_pick #(.N(NREQ), .LW(LW)) u_pick_all (
      .valid  (bus.req_valid),
      .last   (last_winner),
      .onehot (rr_oh),
      .idx    (rr_idx),
      .found  (rr_found)
   );

   rr_pick #(.N(NREQ), .LW(LW)) u_pick_others (
      .valid  (others),
      .last   (last_winner),
      .onehot (oth_oh),
      .idx    (oth_idx),
      .found  (oth_found)
   );

   // Grant decision; a new owner enters LOCK with one grant counted if it asks to lock.
   always_comb begin
      grant_oh  = '0;
      win_idx   = last_winner;
      state_nx  = state;
      cnt_nx    = lock_cnt;
      new_owner = 1'b0;
      if (reset && bus.mem_ready) begin
         case (state)
            LOCK: begin
               if (owner_valid && owner_lock) begin
                  if (lock_cnt < CW'(LOCK_MAX)) begin
                     grant_oh = owner_oh;
                     cnt_nx   = lock_cnt + CW'(1);
                  end else if (oth_found) begin
                     grant_oh  = oth_oh;
                     win_idx   = oth_idx;
                     new_owner = 1'b1;
                  end else begin
                     grant_oh = owner_oh;
                  end
               end else if (oth_found) begin
                  grant_oh  = oth_oh;
                  win_idx   = oth_idx;
                  new_owner = 1'b1;
               end else begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end
            end
            default: begin
               if (rr_found) begin
                  grant_oh  = rr_oh;
                  win_idx   = rr_idx;
                  new_owner = 1'b1;
               end else begin
                  state_nx = IDLE;
               end
            end
         endcase
         if (new_owner) begin
            if (|(bus.req_lock & grant_oh)) begin
               state_nx = LOCK;
               cnt_nx   = CW'(1);
            end else begin
               state_nx = ARB;
               cnt_nx   = '0;
            end
         end
      end
   end

   always_comb begin
      win_addr = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_oh[i]) win_addr = bus.req_addr[i*AW +: AW];
      end
   end

   // FSM, round-robin pointer and the grant -> memory -> response pipeline.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         last_winner <= LW'(NREQ - 1);
         lock_cnt    <= '0;
         owner_d1    <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state     <= state_nx;
         lock_cnt  <= cnt_nx;
         mem_req_q <= |grant_oh;
         if (|grant_oh) begin
            last_winner <= win_idx;
            owner_d1    <= win_idx;
            mem_addr_q  <= win_addr;
         end
         rsp_valid_q <= mem_req_q ? d1_oh : '0;
         if (mem_req_q) rsp_data_q <= bus.mem_data;
      end
   end

   assign bus.req_grant = grant_oh;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = mem_req_q | (|rsp_valid_q) | (state == LOCK);

endmodule

// File: tb/tb_gray_mem_arb.sv
// Directed bench for gray_mem_arb: the driver checks grants and queues the expected
// memory reads and responses; a monitor checks them when they fall due.
module tb_gray_mem_arb;

   logic clk;
   logic reset;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   typedef struct {
      int          due;
      logic [13:0] addr;
   } mem_exp_t;

   typedef struct {
      int          due;
      logic [1:0]  oh;
      logic [7:0]  data;
   } rsp_exp_t;

   mem_exp_t mem_q[$];
   rsp_exp_t rsp_q[$];

   gray_mem_arb_if #(.NREQ(2), .AW(14), .DW(8)) bus ();

   gray_mem_arb #(.NREQ(2), .AW(14), .DW(8), .LOCK_MAX(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Memory contents: pixel value derived from its address (0x0000 -> 0x10).
   function automatic logic [7:0] mem_model(input logic [13:0] a);
      return (a[7:0] + 8'h10) ^ {a[13:8], 2'b00};
   endfunction

   assign bus.mem_data = mem_model(bus.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
      end
   endtask

   task automatic applyStimulus(input logic rst_n, input logic ready, input logic [1:0] v,
                                input logic [1:0] lk, input logic [13:0] a0,
                                input logic [13:0] a1, input logic [1:0] exp_g);
      logic [13:0] ea;
      @(posedge clk);
      #1;
      reset         = rst_n;
      bus.mem_ready = ready;
      bus.req_valid = v;
      bus.req_lock  = lk;
      bus.req_addr  = {a1, a0};
      #2;
      // Reads not yet visible when reset is applied are discarded.
      if (!rst_n) begin
         while (mem_q.size() > 0 && mem_q[mem_q.size()-1].due > cyc) void'(mem_q.pop_back());
         while (rsp_q.size() > 0 && rsp_q[rsp_q.size()-1].due > cyc) void'(rsp_q.pop_back());
      end
      checkOutput("req_grant", 32'(bus.req_grant), 32'(exp_g));
      if (exp_g != 2'b00) begin
         ea = exp_g[0] ? a0 : a1;
         mem_q.push_back('{due: cyc + 1, addr: ea});
         rsp_q.push_back('{due: cyc + 2, oh: exp_g, data: mem_model(ea)});
      end
   endtask

   task automatic checkResetState();
      checkOutput("rst_req_grant", 32'(bus.req_grant), 32'd0);
      checkOutput("rst_mem_req",   32'(bus.mem_req),   32'd0);
      checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
      checkOutput("rst_busy",      32'(bus.busy),      32'd0);
   endtask

   always @(negedge clk) begin
      if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
         checkOutput("mem_req",  32'(bus.mem_req),  32'd1);
         checkOutput("mem_addr", 32'(bus.mem_addr), 32'(mem_q[0].addr));
         void'(mem_q.pop_front());
      end else begin
         checkOutput("mem_idle", 32'(bus.mem_req), 32'd0);
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
         checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_q[0].oh));
         checkOutput("rsp_data",  32'(bus.rsp_data),  32'(rsp_q[0].data));
         void'(rsp_q.pop_front());
      end else begin
         checkOutput("rsp_idle", 32'(bus.rsp_valid), 32'd0);
      end
   end

   initial begin
      reset         = 1'b0;
      bus.mem_ready = 1'b1;
      bus.req_valid = '0;
      bus.req_lock  = '0;
      bus.req_addr  = '0;

      applyStimulus(0, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(0, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      checkResetState();

      // Single requester, back-to-back reads of 0x10, 0x11, 0x12.
      applyStimulus(1, 1, 2'b01, 2'b00, 14'h0000, 14'h0, 2'b01);
      applyStimulus(1, 1, 2'b01, 2'b00, 14'h0001, 14'h0, 2'b01);
      applyStimulus(1, 1, 2'b01, 2'b00, 14'h0002, 14'h0, 2'b01);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);

      // Fair alternation straight after reset.
      applyStimulus(0, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0100, 14'h0200, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0101, 14'h0200, 2'b10);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0101, 14'h0201, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0102, 14'h0201, 2'b10);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0102, 14'h0202, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0103, 14'h0202, 2'b10);

      // Requester 0 locks while requester 1 waits: 0,0,0,1,0,0,0,1.
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0300, 14'h03F0, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0301, 14'h03F0, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0302, 14'h03F0, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0303, 14'h03F0, 2'b10);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0303, 14'h03F1, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0304, 14'h03F1, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0305, 14'h03F1, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0306, 14'h03F1, 2'b10);

      // Stall after two locked grants; the third locked grant follows the stall.
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0307, 14'h03F2, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0308, 14'h03F2, 2'b01);
      for (int k = 0; k < 4; k++)
         applyStimulus(1, 0, 2'b11, 2'b01, 14'h0309, 14'h03F2, 2'b00);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h0309, 14'h03F2, 2'b01);
      applyStimulus(1, 1, 2'b11, 2'b01, 14'h030A, 14'h03F2, 2'b10);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);

      // Reset one cycle after a grant drops the in-flight read.
      applyStimulus(1, 1, 2'b01, 2'b00, 14'h0050, 14'h0, 2'b01);
      applyStimulus(0, 1, 2'b01, 2'b00, 14'h0051, 14'h0, 2'b00);
      applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);
      checkResetState();
      applyStimulus(1, 1, 2'b11, 2'b00, 14'h0060, 14'h00A0, 2'b01);
      for (int k = 0; k < 3; k++)
         applyStimulus(1, 1, 2'b00, 2'b00, 14'h0, 14'h0, 2'b00);

      checkOutput("queue_drained", 32'(mem_q.size() + rsp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gray_mem_arb.md
# gray_mem_arb

- Shares the single-port 128x128 gray-image memory between `NREQ` pixel requesters, e.g. the LBP engine and a second image-processing engine.
- Grants one read per cycle, round-robin, with bounded burst locking so a requester can fetch a 3-pixel window column uninterrupted.
- Routes each read's return data back to the requester that issued it.
- Sits between the engines and the gray memory model; the memory side is identical to the LBP engine's gray port.

## Interface

Parameters:

- `NREQ`, 2: number of requesters (2..4).
- `AW`, 14: pixel address width (128x128 image).
- `DW`, 8: pixel width.
- `LOCK_MAX`, 3: maximum consecutive grants to one locking requester while another requester waits.

Ports:

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-low; sampled on `clk` rising edge; all state cleared while 0.
- `mem_ready`  in  1: memory available; no grant is issued while 0.
- `mem_req`  out  1: read strobe to the gray memory.
- `mem_addr`  out  AW: read address, valid while `mem_req`=1.
- `mem_data`  in  DW: read data, valid during the `mem_req` cycle and sampled at its closing edge.
- `req_valid`  in  NREQ: per-requester read request; held until granted.
- `req_addr`  in  NREQ*AW: per-requester address; slice i is bits [i*AW +: AW].
- `req_lock`  in  NREQ: requester asks to keep ownership after its current grant.
- `req_grant`  out  NREQ: one-hot, combinational; the request is accepted this cycle.
- `rsp_valid`  out  NREQ: one-hot, registered; `rsp_data` belongs to this requester.
- `rsp_data`  out  DW: registered shared return bus.
- `busy`  out  1: a read is in flight or a lock is held.

## Operation

FSM states:

- `IDLE`: no owner.
  - Any `req_valid` with `mem_ready`=1 → grant the round-robin winner → `ARB`.
  - If the winner also asserts `req_lock` → `LOCK` instead.
- `ARB`: arbitrate every cycle.
  - Search starts at `last_winner+1` (mod NREQ).
  - No `req_valid` → `IDLE`.
- `LOCK`: owner = last winner; `lock_cnt` counts consecutive grants, starting at 1.
  - Owner `req_valid`=1, `req_lock`=1, and `lock_cnt` < `LOCK_MAX` → grant the owner again; `lock_cnt`+1.
  - `lock_cnt` = `LOCK_MAX` with another requester waiting → forced round-robin to the next waiting requester; `lock_cnt` cleared.
  - `lock_cnt` = `LOCK_MAX` with no other requester waiting → owner may continue; counter saturates and the owner stays granted.
  - Owner drops `req_lock`, or drops `req_valid` → release; same-cycle round-robin among the others → `ARB` or `IDLE`.

Grant rules:

- `mem_ready`=0 → no grant in any state.
  - State, `last_winner` and `lock_cnt` hold.
  - In-flight reads still complete.
- `req_grant` is asserted only for a requester with `req_valid`=1; at most one bit is set.
- On grant, `mem_req`<=1 and `mem_addr`<=slice of the winner are registered for the next cycle; the winner index is registered as `owner_d1`.
- Return path: on the cycle after `mem_req`, `rsp_data`<=`mem_data` sampled at the end of the `mem_req` cycle, and `rsp_valid`<=onehot(`owner_d1`).
- Responses are returned in grant order; no reordering or buffering is needed, since the latency is fixed.

Width rules:

- `lock_cnt` is $clog2(`LOCK_MAX`+1) bits.
- `last_winner` is $clog2(`NREQ`) bits and wraps mod `NREQ`; for non-power-of-2 values, explicit compare with `NREQ`-1.

## Timing

- Grant at cycle N → `mem_req`/`mem_addr` at N+1 → `rsp_valid`/`rsp_data` at N+2. Fixed latency of 2, throughput of 1 read/cycle.
- Reset values:
  - `mem_req`=0, `mem_addr`=0, `rsp_valid`=0, `rsp_data`=0, `busy`=0, `req_grant`=0.
  - state `IDLE`, `last_winner`=`NREQ`-1 (so requester 0 wins first), `lock_cnt`=0.
- Reset mid-flight discards pending reads: no `rsp_valid` after reset.
- `req_grant` depends combinationally on `req_valid`, `req_lock` and `mem_ready`. Requesters must not drive `req_valid` combinationally from `req_grant`.
- `busy` = `mem_req` | (|`rsp_valid` pending) | (state==`LOCK`).

## Structure

- Shared package `gray_pkg`:
  - `IMG_W`=128, `IMG_H`=128, `AW`, `DW`.
  - FSM state enum `arb_state_t`.
- One sub-module `rr_pick`: combinational round-robin one-hot picker (`valid` vector, `last` index → one-hot, index).
- The FSM, lock counter and return pipeline live in `gray_mem_arb`.

## Test plan

- **Single requester:** requester 0 requests 0x0000, 0x0001, 0x0002 back-to-back; memory holds 0x10, 0x11, 0x12 → grants in consecutive cycles, `rsp_valid[0]` at grant+2 returning 0x10, 0x11, 0x12, `rsp_valid[1]` never set.
- **Fair alternation:** both requesters request continuously with no lock, starting after reset → grants 0,1,0,1…; `mem_addr` alternates between the two address streams.
- **Lock bound:** requester 0 has `req_lock`=1 while requester 1 waits, `LOCK_MAX`=3 → grants 0,0,0,1,0,0,0,1.
- **Memory stall:** `mem_ready`=0 for 4 cycles mid-stream → `req_grant`=0 and `mem_req`=0 from the next cycle; the two already-granted reads still return; after resume, round-robin order and `lock_cnt` continue unchanged.
- **Reset mid-flight:** `reset`=0 one cycle after a grant → the following cycle shows all outputs 0 and no late `rsp_valid`; after release, requester 0 wins first.
